// File: rtl/axi_st_pkg.sv
// Shared types and helpers for the AXI4-Stream round-robin arbiter.
// Holds the FSM encoding, default sizing constants and the wrap-around index helper.
package axi_st_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int DEF_N_SRC  = 4;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 16;

    // Index following idx in a ring of n entries.
    function automatic int next_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer,
// searching upward with wrap-around.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  in_req,
    input  logic [IW-1:0] in_ptr,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    // Scan the ring starting at the pointer; the first hit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < N; k++) begin
            logic [IW-1:0] cand_idx;
            logic          hit;
            cand_idx = IW'((int'(in_ptr) + k) % N);
            hit      = !o_found && in_req[cand_idx];
            o_idx    = hit ? cand_idx : o_idx;
            o_found  = o_found | hit;
        end
    end

endmodule

// File: rtl/axi_st_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream master among N_SRC sources,
// with a registered output stage, packet counter and grant/busy status.
module axi_st_rr_arbiter
    import axi_st_pkg::*;
#(
    parameter int N_SRC  = DEF_N_SRC,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                      in_clk,
    input  logic                      in_rst,
    input  logic [N_SRC-1:0]          in_s_tvalid,
    input  logic [N_SRC*DATA_W-1:0]   in_s_tdata,
    input  logic [N_SRC-1:0]          in_s_tlast,
    output logic [N_SRC-1:0]          o_s_tready,
    output logic                      o_m_tvalid,
    output logic [DATA_W-1:0]         o_m_tdata,
    output logic                      o_m_tlast,
    input  logic                      in_m_tready,
    output logic [$clog2(N_SRC)-1:0]  o_grant,
    output logic                      o_busy,
    output logic [CNT_W-1:0]          o_pkt_cnt
);

    localparam int GW = $clog2(N_SRC);

    state_e              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic                m_tvalid_q, m_tvalid_d;
    logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
    logic                m_tlast_q, m_tlast_d;
    logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;

    logic                pick_found;
    logic [GW-1:0]       pick_idx;
    logic                out_free;
    logic                accept;
    logic                sel_valid;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_data;

    rr_pick #(
        .N  (N_SRC),
        .IW (GW)
    ) u_pick (
        .in_req  (in_s_tvalid),
        .in_ptr  (ptr_q),
        .o_found (pick_found),
        .o_idx   (pick_idx)
    );

    assign sel_valid = in_s_tvalid[grant_q];
    assign sel_last  = in_s_tlast[grant_q];
    assign sel_data  = in_s_tdata[int'(grant_q)*DATA_W +: DATA_W];

    // Output slot can take a beat when empty or draining this cycle.
    assign out_free = !m_tvalid_q || in_m_tready;
    assign accept   = (state_q == ST_BUSY) && sel_valid && out_free;

    // Only the granted source sees tready, and only while locked.
    always_comb begin
        o_s_tready = '0;
        if (state_q == ST_BUSY) begin
            o_s_tready[grant_q] = out_free;
        end else begin
            o_s_tready = '0;
        end
    end

    // Arbitration FSM: pick in IDLE, hold the grant until a TLAST beat is accepted.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (accept && sel_last) begin
                    state_d = ST_IDLE;
                    ptr_d   = GW'(next_idx(int'(grant_q), N_SRC));
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register: load on accept, drain on ready, otherwise hold.
    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        if (accept) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = sel_data;
            m_tlast_d  = sel_last;
        end else if (in_m_tready) begin
            m_tvalid_d = 1'b0;
        end else begin
            m_tvalid_d = m_tvalid_q;
        end
    end

    // Packet counter advances on each downstream TLAST handshake.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (m_tvalid_q && in_m_tready && m_tlast_q) begin
            pkt_cnt_d = pkt_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
    end

    // State and output flops with synchronous reset.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign o_m_tvalid = m_tvalid_q;
    assign o_m_tdata  = m_tdata_q;
    assign o_m_tlast  = m_tlast_q;
    assign o_grant    = grant_q;
    assign o_busy     = (state_q == ST_BUSY);
    assign o_pkt_cnt  = pkt_cnt_q;

endmodule

// File: doc/axi_st_rr_arbiter.md
Name: axi_st_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream AXI4-Stream channel among N upstream sources.
- Grant is held for a whole packet (until a TLAST beat is accepted); the output is registered.
- Sits in front of the axi4_st sink: it sequences which producer drives in_data and when the transfer proceeds.
- Also provides a packet counter and busy/grant status for software-visible debug.

Parameters:
- N_SRC, 4, number of upstream sources (2..8).
- DATA_W, 16, TDATA width in bits.
- CNT_W, 16, width of the forwarded-packet counter.

Ports:
- in_clk  input  1  clock; all logic on rising edge.
- in_rst  input  1  synchronous reset, active-high.
- in_s_tvalid  input  N_SRC  per-source TVALID.
- in_s_tdata  input  N_SRC*DATA_W  per-source TDATA, flattened; source i occupies bits [i*DATA_W +: DATA_W].
- in_s_tlast  input  N_SRC  per-source TLAST.
- o_s_tready  output  N_SRC  per-source TREADY.
- o_m_tvalid  output  1  downstream TVALID (registered).
- o_m_tdata  output  DATA_W  downstream TDATA (registered).
- o_m_tlast  output  1  downstream TLAST (registered).
- in_m_tready  input  1  downstream TREADY.
- o_grant  output  $clog2(N_SRC)  index of the currently or last granted source.
- o_busy  output  1  high while a packet is locked.
- o_pkt_cnt  output  CNT_W  count of packets forwarded downstream.

Behaviour:
- Reset (in_rst=1 at a clock edge) sets:
  - state to IDLE;
  - o_m_tvalid=0, o_m_tdata=0, o_m_tlast=0;
  - o_s_tready all 0, o_grant=0, o_busy=0, o_pkt_cnt=0;
  - rr pointer to 0.
  - Any in-flight packet is dropped.
- FSM has two states: IDLE and BUSY.
- IDLE:
  - o_s_tready all 0.
  - If any in_s_tvalid is set, select the first source whose tvalid=1, searching from the rr pointer upward with modulo N_SRC wrap.
  - Latch the selection into o_grant and go to BUSY on the next edge.
  - Arbitration costs exactly 1 cycle.
  - No valid sources: stay in IDLE; o_grant holds its previous value.
- BUSY:
  - o_busy=1.
  - o_s_tready[o_grant] = (!o_m_tvalid || in_m_tready). All other tready bits are 0.
  - This tready is combinational from in_m_tready and the output register.
- Input handshake (in_s_tvalid[g] && o_s_tready[g]): on the next edge, o_m_tdata/o_m_tlast load source g's data/last and o_m_tvalid=1.
- Latency from input handshake to output valid is 1 cycle. Full throughput (one beat per cycle) is required while in_m_tready=1.
- Output register:
  - If in_m_tready=1 and no new beat is accepted, o_m_tvalid clears.
  - If in_m_tready=0, o_m_tvalid/tdata/tlast hold stable (AXI rule: no change while valid and not ready).
- Packet end: when the accepted input beat has tlast=1:
  - go to IDLE on the same edge;
  - rr pointer = (g+1) mod N_SRC.
- The following arbitration in IDLE may overlap the output register still holding the last beat. No new input beat is accepted until BUSY.
- o_pkt_cnt increments by 1 on each downstream handshake (o_m_tvalid && in_m_tready && o_m_tlast). It wraps modulo 2^CNT_W.
- A source that deasserts tvalid mid-packet keeps the grant; the arbiter waits indefinitely. There is no timeout.
- A single-beat packet (tlast on the first beat) is legal: the source is granted, accepted and released, and the pointer advances.
- A source that is not granted sees tready=0 regardless of its tvalid.
- Fairness: with all sources continuously valid, grants rotate 0,1,2,3,0,...
- Reset mid-packet: outputs return to reset values on the reset edge. Behaviour after deassertion is as from power-up.

Decomposition:
- Package axi_st_pkg holds:
  - FSM state encoding (ST_IDLE=0, ST_BUSY=1);
  - default DATA_W, N_SRC, CNT_W constants;
  - a function returning the next index with modulo wrap.
- One sub-module: rr_pick. It is combinational; inputs are the request vector and pointer, outputs are the found flag and index. The arbiter instantiates it once.

Test Plan:
- Reset then single source: src1 sends 3 beats (0x00F0, 0x00DC, 0x0104, last on the third) with in_m_tready=1 → o_grant=1; o_m_tdata sequence 0x00F0, 0x00DC, 0x0104 on consecutive cycles, 1 cycle after each input beat; o_pkt_cnt=1.
- All 4 sources valid with 2-beat packets → grant order 0,1,2,3,0; no beats interleave between sources; o_pkt_cnt=5 after 5 packets.
- Backpressure: in_m_tready=0 for 4 cycles mid-packet → o_m_tdata/o_m_tvalid stable; o_s_tready[g]=0 while the output register is full; no beat lost or duplicated once tready returns.
- Granted source drops tvalid for 3 cycles mid-packet while src2 is valid → grant stays on the owner; src2's tready stays 0; the packet completes intact.
- Single-beat packets from src3 only, repeated 3 times → each takes 2 cycles (arbitrate plus transfer); pointer wraps to 0; o_pkt_cnt=3.
- Assert in_rst during the second beat of a packet → the next cycle shows o_m_tvalid=0, o_busy=0, o_pkt_cnt=0; the following packet from src0 is granted first.
